// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg
//   Shared types and helpers for the program-counter sequencer.
//   - jmode_t       : redirect mode encoding (ABS, REL, CALL, RET)
//   - lut_entry_t   : far-jump table entry {rel, val} at the default width
//   - escapeBase()  : first target value that is treated as a far-jump escape
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ABS  = 2'd0,
    REL  = 2'd1,
    CALL = 2'd2,
    RET  = 2'd3
  } jmode_t;

  localparam int DEFAULT_D = 10;

  // Default-width view of a table entry; pc_seq stores the same {rel, val}
  // layout at its own D.
  typedef struct packed {
    logic                 rel;
    logic [DEFAULT_D-1:0] val;
  } lut_entry_t;

  // The top lutN addresses of a d-bit space are reserved as escapes
  // into the far-jump table.
  function automatic int unsigned escapeBase(input int unsigned d, input int unsigned lutN);
    return (32'd1 << d) - lutN;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// pc_ret_stack
//   Circular return-address stack. When full, a push overwrites the oldest
//   entry so the most recent RS_DEPTH return addresses are always kept.
//   Ports:
//     clk, reset (async, active-low)
//     clear    : synchronous empty
//     push     : store pushData on top
//     pop      : remove top entry (ignored when empty)
//     pushData : return address to store
//     top      : current top-of-stack value
//     depth    : number of live entries
//     ovf/unf  : combinational pulses, push-while-full / pop-while-empty
module pc_ret_stack #(
  parameter int RS_DEPTH = 4,
  parameter int D        = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          push,
  input  logic                          pop,
  input  logic [D-1:0]                  pushData,
  output logic [D-1:0]                  top,
  output logic [$clog2(RS_DEPTH+1)-1:0] depth,
  output logic                          ovf,
  output logic                          unf
);

  localparam int PW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
  localparam int DW = $clog2(RS_DEPTH+1);

  logic [D-1:0]  mem [RS_DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] topPtr;
  logic [PW-1:0] nextPtr;
  logic          full;
  logic          empty;

  // wrPtr is the next free slot; when full it is also the oldest entry,
  // which is exactly the slot a wrapping push should overwrite.
  always_comb begin
    full    = (depth == DW'(RS_DEPTH));
    empty   = (depth == '0);
    topPtr  = (wrPtr == '0) ? PW'(RS_DEPTH-1) : wrPtr - PW'(1);
    nextPtr = (wrPtr == PW'(RS_DEPTH-1)) ? '0 : wrPtr + PW'(1);
    top     = mem[topPtr];
    ovf     = push && full;
    unf     = pop && empty;
  end

  // Pointer and occupancy tracking; clear beats push, push beats pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      depth <= '0;
    end else if (clear) begin
      wrPtr <= '0;
      depth <= '0;
    end else if (push) begin
      wrPtr <= nextPtr;
      if (!full) depth <= depth + DW'(1);
    end else if (pop && !empty) begin
      wrPtr <= topPtr;
      depth <= depth - DW'(1);
    end
  end

  // Storage needs no reset: occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/pc_seq.sv
// pc_seq
//   Program-counter sequencer: one PC per clock with relative branches,
//   programmable far-jump table, call/return stack and stall.
//   Ports:
//     clk, reset (async, active-low), start (sync restart), stall
//     jumpEn/jmode/target : redirect request (ABS, REL, CALL, RET)
//     lut_we/lut_idx/lut_rel/lut_val : far-jump table write port
//     programCounter : registered PC
//     rs_depth       : live return-stack entries
//     rs_ovf/rs_unf  : sticky stack overflow/underflow flags
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int D        = 10,
  parameter int LUT_N    = 4,
  parameter int RS_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          stall,
  input  logic                          jumpEn,
  input  logic [1:0]                    jmode,
  input  logic [D-1:0]                  target,
  input  logic                          lut_we,
  input  logic [$clog2(LUT_N)-1:0]      lut_idx,
  input  logic                          lut_rel,
  input  logic [D-1:0]                  lut_val,
  output logic [D-1:0]                  programCounter,
  output logic [$clog2(RS_DEPTH+1)-1:0] rs_depth,
  output logic                          rs_ovf,
  output logic                          rs_unf
);

  localparam int IW = $clog2(LUT_N);
  localparam logic [D-1:0] ESC_BASE = D'(escapeBase(D, LUT_N));

  // Each entry is {rel, val}, same layout as lut_entry_t.
  logic [D:0]   lutMem [LUT_N];
  logic [D:0]   entry;
  jmode_t       mode;
  logic [D-1:0] pcInc;
  logic [D-1:0] farPc;
  logic [D-1:0] resolved;
  logic [D-1:0] nextPc;
  logic [D-1:0] stackTop;
  logic         doJump;
  logic         push;
  logic         pop;
  logic         ovfPulse;
  logic         unfPulse;

  assign mode = jmode_t'(jmode);

  // Target resolution and next-PC selection. D-bit unsigned adds give the
  // required modulo-2^D behaviour for signed offsets as well. The table is
  // read from its registered contents, so a same-cycle write is not seen.
  always_comb begin
    pcInc    = programCounter + D'(1);
    entry    = lutMem[target[IW-1:0]];
    farPc    = entry[D] ? programCounter + entry[D-1:0] : entry[D-1:0];
    resolved = (target >= ESC_BASE) ? farPc : target;
    doJump   = jumpEn && !stall && !start;
    push     = doJump && (mode == CALL);
    pop      = doJump && (mode == RET);
    nextPc   = pcInc;
    if (jumpEn) begin
      case (mode)
        ABS:     nextPc = resolved;
        REL:     nextPc = programCounter + target;
        CALL:    nextPc = resolved;
        RET:     nextPc = (rs_depth != '0) ? stackTop : pcInc;
        default: nextPc = pcInc;
      endcase
    end
  end

  pc_ret_stack #(
    .RS_DEPTH(RS_DEPTH),
    .D       (D)
  ) u_stack (
    .clk     (clk),
    .reset   (reset),
    .clear   (start),
    .push    (push),
    .pop     (pop),
    .pushData(pcInc),
    .top     (stackTop),
    .depth   (rs_depth),
    .ovf     (ovfPulse),
    .unf     (unfPulse)
  );

  // PC register: start restarts at 0 even while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      programCounter <= '0;
    end else if (start) begin
      programCounter <= '0;
    end else if (!stall) begin
      programCounter <= nextPc;
    end
  end

  // Sticky stack flags; the pulses are already gated by stall/start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs_ovf <= 1'b0;
      rs_unf <= 1'b0;
    end else if (start) begin
      rs_ovf <= 1'b0;
      rs_unf <= 1'b0;
    end else begin
      if (ovfPulse) rs_ovf <= 1'b1;
      if (unfPulse) rs_unf <= 1'b1;
    end
  end

  // Far-jump table: only reset clears it; writes ignore stall and start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LUT_N; i++) lutMem[i] <= '0;
    end else if (lut_we) begin
      lutMem[lut_idx] <= {lut_rel, lut_val};
    end
  end

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq
//   Scoreboard bench for pc_seq: the driver updates a behavioural model and
//   queues the expected outputs; a monitor pops and compares them.
module tb_pc_seq;

  localparam int D        = 10;
  localparam int LUT_N    = 4;
  localparam int RS_DEPTH = 4;
  localparam int PCMOD    = 1 << D;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         stall = 1'b0;
  logic         jumpEn = 1'b0;
  logic [1:0]   jmode = 2'd0;
  logic [D-1:0] target = '0;
  logic         lut_we = 1'b0;
  logic [1:0]   lut_idx = 2'd0;
  logic         lut_rel = 1'b0;
  logic [D-1:0] lut_val = '0;
  logic [D-1:0] programCounter;
  logic [2:0]   rs_depth;
  logic         rs_ovf;
  logic         rs_unf;

  pc_seq #(.D(D), .LUT_N(LUT_N), .RS_DEPTH(RS_DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stall         (stall),
    .jumpEn        (jumpEn),
    .jmode         (jmode),
    .target        (target),
    .lut_we        (lut_we),
    .lut_idx       (lut_idx),
    .lut_rel       (lut_rel),
    .lut_val       (lut_val),
    .programCounter(programCounter),
    .rs_depth      (rs_depth),
    .rs_ovf        (rs_ovf),
    .rs_unf        (rs_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pc;
    int depth;
    int ovf;
    int unf;
    int step;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   fails = 0;
  int   stepNo = 0;
  event sampleNow;

  // Reference model state: PC as an integer, the stack as a queue whose
  // back is the top, and the table as two plain arrays.
  int mPc;
  int mStack[$];
  int mOvf;
  int mUnf;
  int mRel[LUT_N];
  int mVal[LUT_N];

  function automatic int wrapPc(input int v);
    return ((v % PCMOD) + PCMOD) % PCMOD;
  endfunction

  function automatic int toSigned(input int v);
    return (v >= PCMOD / 2) ? v - PCMOD : v;
  endfunction

  function automatic int farTarget(input int t);
    int idx;
    if (t < PCMOD - LUT_N) return t;
    idx = t % LUT_N;
    if (mRel[idx] != 0) return wrapPc(mPc + toSigned(mVal[idx]));
    return mVal[idx];
  endfunction

  task automatic modelReset();
    mPc = 0;
    mStack.delete();
    mOvf = 0;
    mUnf = 0;
    for (int i = 0; i < LUT_N; i++) begin
      mRel[i] = 0;
      mVal[i] = 0;
    end
  endtask

  task automatic modelStep(input bit st, input bit sl, input bit je, input int jm,
                           input int tg, input bit we, input int idx, input bit rel,
                           input int val);
    int ret;
    int dest;
    if (st) begin
      mPc = 0;
      mStack.delete();
      mOvf = 0;
      mUnf = 0;
    end else if (!sl) begin
      if (!je) begin
        mPc = wrapPc(mPc + 1);
      end else begin
        case (jm)
          0: mPc = farTarget(tg);
          1: mPc = wrapPc(mPc + toSigned(tg));
          2: begin
            ret  = wrapPc(mPc + 1);
            dest = farTarget(tg);
            if (mStack.size() == RS_DEPTH) begin
              void'(mStack.pop_front());
              mOvf = 1;
            end
            mStack.push_back(ret);
            mPc = dest;
          end
          default: begin
            if (mStack.size() > 0) mPc = mStack.pop_back();
            else begin
              mPc  = wrapPc(mPc + 1);
              mUnf = 1;
            end
          end
        endcase
      end
    end
    if (we) begin
      mRel[idx] = rel;
      mVal[idx] = val;
    end
  endtask

  task automatic pushExpected();
    exp_t e;
    e.pc    = mPc;
    e.depth = mStack.size();
    e.ovf   = mOvf;
    e.unf   = mUnf;
    e.step  = stepNo;
    expQ.push_back(e);
    stepNo++;
  endtask

  task automatic applyStimulus(input bit st, input bit sl, input bit je, input int jm,
                               input int tg, input bit we, input int idx, input bit rel,
                               input int val);
    start   = st;
    stall   = sl;
    jumpEn  = je;
    jmode   = 2'(jm);
    target  = D'(tg);
    lut_we  = we;
    lut_idx = 2'(idx);
    lut_rel = rel;
    lut_val = D'(val);
    @(posedge clk);
    #1;
    modelStep(st, sl, je, jm, tg, we, idx, rel, val);
    pushExpected();
    start  = 1'b0;
    stall  = 1'b0;
    jumpEn = 1'b0;
    lut_we = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic jump(input int jm, input int tg);
    applyStimulus(0, 0, 1, jm, tg, 0, 0, 0, 0);
  endtask

  task automatic lutWrite(input int idx, input bit rel, input int val);
    applyStimulus(0, 0, 0, 0, 0, 1, idx, rel, val);
  endtask

  // Assert reset between edges and sample before the next rising edge, so
  // only an asynchronous reset can make the check pass.
  task automatic applyReset();
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    modelReset();
    pushExpected();
    ->sampleNow;
    #1;
    reset = 1'b1;
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (int'(programCounter) != e.pc) begin
      fails++;
      $display("[TB] FAIL pc step %0d: got %0d, expected %0d", e.step, programCounter, e.pc);
    end
    checks++;
    if (int'(rs_depth) != e.depth) begin
      fails++;
      $display("[TB] FAIL rs_depth step %0d: got %0d, expected %0d", e.step, rs_depth, e.depth);
    end
    checks++;
    if (int'(rs_ovf) != e.ovf) begin
      fails++;
      $display("[TB] FAIL rs_ovf step %0d: got %0d, expected %0d", e.step, rs_ovf, e.ovf);
    end
    checks++;
    if (int'(rs_unf) != e.unf) begin
      fails++;
      $display("[TB] FAIL rs_unf step %0d: got %0d, expected %0d", e.step, rs_unf, e.unf);
    end
  endtask

  // Monitor: the DUT presents a new PC every cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or sampleNow);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: got no end of stimulus, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit st;
    bit sl;
    bit je;
    bit we;
    bit rel;
    int jm;
    int tg;
    int idx;
    int val;

    $display("[TB] pc_seq scoreboard bench");
    applyReset();
    repeat (5) idle();
    applyReset();

    // ABS / REL / wrap
    jump(0, 100);
    jump(1, 'h3FD);
    jump(0, 1019);
    repeat (5) idle();
    jump(0, 1019);
    idle();
    idle();
    jump(1, 5);

    // Far-jump table
    lutWrite(3, 0, 237);
    lutWrite(2, 0, 285);
    lutWrite(1, 1, 'h3FD);
    jump(0, 1023);
    jump(0, 1022);
    jump(0, 50);
    jump(0, 1021);
    applyStimulus(0, 0, 1, 0, 1023, 1, 3, 0, 400);
    jump(0, 1023);

    // Call / return stack
    jump(0, 10);
    jump(2, 200);
    jump(3, 0);
    for (int i = 0; i < 5; i++) jump(2, 300 + i * 7);
    for (int i = 0; i < 5; i++) jump(3, 0);

    // Stall / start
    jump(0, 50);
    jump(2, 120);
    applyStimulus(0, 1, 1, 0, 300, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 2, 300, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 300, 0, 0, 0, 0);
    jump(0, 1023);
    jump(2, 1021);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        applyReset();
      end else begin
        st  = ($urandom_range(0, 49) == 0);
        sl  = ($urandom_range(0, 7) == 0);
        je  = ($urandom_range(0, 2) != 0);
        jm  = int'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) tg = PCMOD - 1 - int'($urandom_range(0, LUT_N - 1));
        else tg = int'($urandom_range(0, PCMOD - 1));
        we  = ($urandom_range(0, 5) == 0);
        idx = int'($urandom_range(0, LUT_N - 1));
        rel = $urandom_range(0, 1) == 1;
        val = int'($urandom_range(0, PCMOD - 1));
        applyStimulus(st, sl, je, jm, tg, we, idx, rel, val);
      end
    end

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pc_seq.md
# pc_seq

Parametrised program-counter sequencer, the next generation of the core's PC register. It adds:
- signed relative branches;
- a programmable far-jump table that replaces hard-wired magic targets;
- a call/return stack with overflow/underflow flags;
- a stall input.

It sits between the decoder/branch logic and instruction-memory address input, and produces one PC per clock.

## Interface
Parameters:
- D, 10, PC and target width in bits
- LUT_N, 4, far-jump table entries (power of 2, ≥2)
- RS_DEPTH, 4, return-stack entries (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  synchronous restart: PC←0, stack emptied, sticky flags cleared
- stall  in  1  hold PC and stack; ignore jump request
- jumpEn  in  1  redirect request, qualified by jmode
- jmode  in  2  ABS=0, REL=1, CALL=2, RET=3
- target  in  D  absolute address, signed offset (REL), or far-jump escape
- lut_we  in  1  far-jump table write strobe
- lut_idx  in  $clog2(LUT_N)  table write index
- lut_rel  in  1  entry is relative (PC+value) rather than absolute
- lut_val  in  D  entry value
- programCounter  out  D  current PC
- rs_depth  out  $clog2(RS_DEPTH+1)  live stack entries
- rs_ovf  out  1  sticky: a CALL found the stack full
- rs_unf  out  1  sticky: a RET found the stack empty

## Operation
- Priority each cycle: reset > start > stall > jumpEn > increment (PC+1).
- ABS:
  - if target < 2^D−LUT_N, PC←target.
  - Otherwise it is a far-jump escape: idx = target[$clog2(LUT_N)-1:0].
  - The entry with rel=0 gives PC←val; rel=1 gives PC←PC+val (signed).
- REL: PC←PC+target, target treated as D-bit two's complement.
- CALL:
  - push PC+1; PC←target. Same escape decode as ABS.
  - If the stack is full: the oldest entry is discarded (circular), the push succeeds, rs_ovf←1, rs_depth stays RS_DEPTH.
- RET:
  - if stack non-empty: PC←top, pop.
  - If empty: PC←PC+1, rs_unf←1.
- All PC arithmetic is modulo 2^D. 2^D−1 + 1 wraps to 0. Negative offsets wrap likewise.
- Table write: lut_we writes {lut_rel, lut_val} at lut_idx. It is independent of stall and jumps.
  - A same-cycle jump through the same index uses the old entry.
- Stall: PC, stack, and flags are unchanged. lut_we still takes effect. Start overrides stall.
- Far-jump table contents survive start. They are cleared to {0,0} only by reset.

## Timing
- Reset (async assert, sync release): programCounter=0, rs_depth=0, rs_ovf=0, rs_unf=0, table all zero.
- Latency: a redirect presented in cycle n appears on programCounter after edge n (one cycle). No bubbles. Fetch consumes the registered PC.
- Back-to-back CALL/RET in consecutive cycles is legal. RET immediately after CALL returns the just-pushed PC+1.
- Reset asserted mid-stream takes effect immediately, without a clock. The first edge after deassertion yields PC=1 unless start, stall, or a jump applies.

## Structure
- Package pc_seq_pkg:
  - jmode_t enum (ABS, REL, CALL, RET)
  - lut_entry_t packed struct {logic rel; logic [D-1:0] val} (parametrised via localparam default D=10)
  - escape-base helper function
- Sub-module pc_ret_stack:
  - parameters RS_DEPTH and D
  - circular buffer with push/pop/clear
  - outputs top, depth, ovf/unf pulses
  - pc_seq owns the sticky flags.
- Far-jump table is an inline register array; no RAM macro.

## Test plan
All scenarios use D=10, LUT_N=4, RS_DEPTH=4.
- Reset/increment: release reset, 5 idle cycles -> PC 0,1,2,3,4,5; assert reset mid-cycle at PC=5 -> PC=0 before next edge.
- ABS/REL/wrap:
  - ABS 100 -> PC=100.
  - Then REL target=10'h3FD (−3) -> PC=97.
  - From PC=1023 increment -> 0.
  - REL +5 at PC=1021 -> 2.
- Far-jump table:
  - write idx3={0,237} and idx2={0,285}, idx1={1,−3}.
  - ABS 1023 -> 237; ABS 1022 -> 285; ABS 1021 at PC=50 -> 47.
  - Write idx3={0,400} in the same cycle as ABS 1023 -> 237, and the next ABS 1023 -> 400.
- Stack:
  - CALL 200 at PC=10 -> PC=200, depth=1; RET -> PC=11, depth=0.
  - 5 CALLs -> rs_ovf=1, depth=4; 4 RETs return the last 4 return addresses; 5th RET -> PC+1, rs_unf=1.
- Stall/start:
  - stall with jumpEn ABS 300 -> PC unchanged, depth unchanged.
  - start during stall -> PC=0, depth=0, flags cleared, table entries retained.
